// File: rtl/nzr_grb_receiver.sv
// ---------------------------------------------------------------------------
// nzr_grb_receiver
//   Receive side of the WS2812B NZR single-wire protocol. Each high pulse on
//   din is measured in clk ticks and classified as a '0' or '1' bit. Bits are
//   collected MSB-first into 24-bit GRB words. The module counts the words in
//   each frame and treats a long low period (the RESET code) as end-of-frame.
//   Used as a loopback checker for the GRB transmitter and as a front end for
//   capturing data on a chain of LEDs. clk is nominally 100 MHz.
//
// Ports
//   clk         in   1   system clock
//   reset       in   1   synchronous, active-high reset
//   din         in   1   asynchronous NZR serial input
//   grb_word    out  24  last completed word {G,R,B}; held until the next word
//   word_valid  out  1   1-clk pulse: grb_word updated this cycle
//   led_index   out  8   0-based index of grb_word within its frame (saturates)
//   frame_done  out  1   1-clk pulse: RESET code seen after at least one word
//   led_count   out  8   word count of the last completed frame
//   err         out  1   1-clk pulse: protocol error
//   err_code    out  2   01 glitch, 10 stuck high, 11 partial word at RESET;
//                        held until the next error or reset
// ---------------------------------------------------------------------------
module nzr_grb_receiver #(
  parameter int T0H_MIN    = 15,
  parameter int BIT_THRESH = 60,
  parameter int T1H_MAX    = 120,
  parameter int RESET_CLKS = 28100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] grb_word,
  output logic        word_valid,
  output logic [7:0]  led_index,
  output logic        frame_done,
  output logic [7:0]  led_count,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [7:0]  T0H      = 8'(T0H_MIN);
  localparam logic [7:0]  BIT_THR  = 8'(BIT_THRESH);
  localparam logic [7:0]  T1H      = 8'(T1H_MAX);
  localparam logic [14:0] LCNT_END = 15'(RESET_CLKS - 1);

  localparam logic [1:0] ERR_GLITCH  = 2'b01;
  localparam logic [1:0] ERR_STUCK   = 2'b10;
  localparam logic [1:0] ERR_PARTIAL = 2'b11;

  typedef enum logic [1:0] {SSYNC, SIDLE, SHIGH, SLOW} state_t;

  state_t      state, state_n;
  logic        din_meta, din_s, din_d;
  logic [7:0]  hcnt, hcnt_n;
  logic [14:0] lcnt, lcnt_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [23:0] shift, shift_n;
  logic [7:0]  word_cnt, word_cnt_n;
  logic [23:0] grb_word_n;
  logic [7:0]  led_index_n, led_count_n;
  logic        word_valid_n, frame_done_n, err_n;
  logic [1:0]  err_code_n;
  logic        rise, fall, bit_val;
  logic [7:0]  hcnt_inc, word_cnt_inc;
  logic [14:0] lcnt_inc;

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

  // Saturating increments: a stuck line must never wrap a counter back into range.
  assign hcnt_inc     = (hcnt == 8'hFF) ? hcnt : hcnt + 8'd1;
  assign lcnt_inc     = (lcnt == 15'h7FFF) ? lcnt : lcnt + 15'd1;
  assign word_cnt_inc = (word_cnt == 8'hFF) ? word_cnt : word_cnt + 8'd1;

  // Bit value is decided by the high time measured up to the falling edge.
  assign bit_val = (hcnt >= BIT_THR);

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_n      = state;
    hcnt_n       = hcnt;
    lcnt_n       = lcnt;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    word_cnt_n   = word_cnt;
    grb_word_n   = grb_word;
    led_index_n  = led_index;
    led_count_n  = led_count;
    err_code_n   = err_code;
    word_valid_n = 1'b0;
    frame_done_n = 1'b0;
    err_n        = 1'b0;

    case (state)
      SSYNC: begin
        // Only a full RESET-length low arms the receiver.
        if (din_s)                  lcnt_n  = '0;
        else if (lcnt == LCNT_END)  state_n = SIDLE;
        else                        lcnt_n  = lcnt_inc;
      end

      SIDLE: begin
        if (rise) begin
          hcnt_n  = 8'd1;
          state_n = SHIGH;
        end
      end

      SHIGH: begin
        // Over-length is checked before the fall so a pulse one tick too
        // long is rejected even if it ends in the same cycle.
        if (hcnt > T1H) begin
          err_n      = 1'b1;
          err_code_n = ERR_STUCK;
        end else if (fall) begin
          if (hcnt < T0H) begin
            err_n      = 1'b1;
            err_code_n = ERR_GLITCH;
          end else begin
            shift_n = {shift[22:0], bit_val};
            lcnt_n  = 15'd1;
            state_n = SLOW;
            if (bit_cnt == 5'd23) begin
              grb_word_n   = {shift[22:0], bit_val};
              word_valid_n = 1'b1;
              led_index_n  = word_cnt;
              word_cnt_n   = word_cnt_inc;
              bit_cnt_n    = '0;
            end else begin
              bit_cnt_n = bit_cnt + 5'd1;
            end
          end
        end else begin
          hcnt_n = hcnt_inc;
        end
      end

      SLOW: begin
        if (rise) begin
          hcnt_n  = 8'd1;
          state_n = SHIGH;
        end else if (lcnt == LCNT_END) begin
          // End of frame; the line has already been low long enough to count
          // as a sync, so the receiver re-arms directly.
          if (bit_cnt != 5'd0) begin
            err_n      = 1'b1;
            err_code_n = ERR_PARTIAL;
          end else if (word_cnt != 8'd0) begin
            frame_done_n = 1'b1;
            led_count_n  = word_cnt;
          end
          word_cnt_n = '0;
          bit_cnt_n  = '0;
          shift_n    = '0;
          lcnt_n     = '0;
          state_n    = SIDLE;
        end else begin
          lcnt_n = lcnt_inc;
        end
      end

      default: state_n = SSYNC;
    endcase

    // Bit-level errors drop the partial frame and force a fresh sync.
    // A partial word at RESET is reported but the line is already synced.
    if (err_n && err_code_n != ERR_PARTIAL) begin
      shift_n    = '0;
      bit_cnt_n  = '0;
      word_cnt_n = '0;
      hcnt_n     = '0;
      lcnt_n     = '0;
      state_n    = SSYNC;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: all of these are plain registers, so every one is reset; nothing
      // here is a memory array that would be left unreset.
      state      <= SSYNC;
      din_meta   <= 1'b0;
      din_s      <= 1'b0;
      din_d      <= 1'b0;
      hcnt       <= '0;
      lcnt       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      word_cnt   <= '0;
      grb_word   <= '0;
      led_index  <= '0;
      led_count  <= '0;
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      din_meta   <= din;
      din_s      <= din_meta;
      din_d      <= din_s;
      state      <= state_n;
      hcnt       <= hcnt_n;
      lcnt       <= lcnt_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      word_cnt   <= word_cnt_n;
      grb_word   <= grb_word_n;
      led_index  <= led_index_n;
      led_count  <= led_count_n;
      word_valid <= word_valid_n;
      frame_done <= frame_done_n;
      err        <= err_n;
      err_code   <= err_code_n;
    end
  end

endmodule

// File: tb/tb_nzr_grb_receiver.sv
// ---------------------------------------------------------------------------
// tb_nzr_grb_receiver
//   Directed bench for nzr_grb_receiver. Expected words, frame ends and
//   errors are queued as stimulus is driven; a negedge monitor pops and
//   compares them whenever the DUT pulses, and flags any pulse nobody expected.
//   RESET_CLKS is shortened so the run stays short; pulse thresholds keep
//   their default values.
// ---------------------------------------------------------------------------
module tb_nzr_grb_receiver;

  localparam int RST_CLKS = 400;
  localparam int LONG_LOW = RST_CLKS + 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic [23:0] grb_word;
  logic        word_valid;
  logic [7:0]  led_index;
  logic        frame_done;
  logic [7:0]  led_count;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] grb;
    logic [7:0]  idx;
  } word_exp_t;

  word_exp_t  word_q[$];
  logic [7:0] frame_q[$];
  logic [1:0] err_q[$];

  logic [7:0] model_idx = 8'd0;
  logic [7:0] model_led = 8'd0;

  nzr_grb_receiver #(
    .T0H_MIN(15), .BIT_THRESH(60), .T1H_MAX(120), .RESET_CLKS(RST_CLKS)
  ) dut (
    .clk(clk), .reset(reset), .din(din),
    .grb_word(grb_word), .word_valid(word_valid), .led_index(led_index),
    .frame_done(frame_done), .led_count(led_count),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Scoreboard monitor: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (word_valid) begin
      check("word_valid_expected", 32'(word_q.size() != 0), 32'd1);
      if (word_q.size() != 0) begin
        word_exp_t w;
        w = word_q.pop_front();
        check("grb_word", 32'(grb_word), 32'(w.grb));
        check("led_index", 32'(led_index), 32'(w.idx));
      end
    end
    if (frame_done) begin
      check("frame_done_expected", 32'(frame_q.size() != 0), 32'd1);
      if (frame_q.size() != 0) check("led_count", 32'(led_count), 32'(frame_q.pop_front()));
    end
    if (err) begin
      check("err_expected", 32'(err_q.size() != 0), 32'd1);
      if (err_q.size() != 0) check("err_code", 32'(err_code), 32'(err_q.pop_front()));
    end
  end

  // All drive tasks are entered on a falling edge and return on one.
  task automatic pulse(input int h, input int l);
    din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(80, 48);
    else   pulse(40, 88);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic low(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_word(input logic [23:0] w);
    word_q.push_back('{grb: w, idx: model_idx});
    if (model_idx != 8'hFF) model_idx++;
  endtask

  task automatic expect_frame();
    frame_q.push_back(model_idx);
    model_led = model_idx;
    model_idx = 8'd0;
  endtask

  task automatic expect_err(input logic [1:0] code);
    err_q.push_back(code);
    model_idx = 8'd0;
  endtask

  // Bounded wait for every queued expectation to be consumed.
  task automatic drain(input string tag);
    for (int i = 0; i < 600; i++) begin
      if (word_q.size() == 0 && frame_q.size() == 0 && err_q.size() == 0) break;
      @(negedge clk);
    end
    check({tag, "_words_pending"}, 32'(word_q.size()), 32'd0);
    check({tag, "_frames_pending"}, 32'(frame_q.size()), 32'd0);
    check({tag, "_errs_pending"}, 32'(err_q.size()), 32'd0);
    word_q.delete();
    frame_q.delete();
    err_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_grb_word"}, 32'(grb_word), 32'd0);
    check({tag, "_led_index"}, 32'(led_index), 32'd0);
    check({tag, "_led_count"}, 32'(led_count), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
    check({tag, "_pulses"}, 32'({word_valid, frame_done, err}), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    din   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: sync, single word, end of frame.
    check_reset_values("rst");
    low(LONG_LOW);
    expect_word(24'hFF0055);
    send_bits(24'hFF0055, 24);
    expect_frame();
    low(LONG_LOW);
    drain("t1");
    check("t1_grb_hold", 32'(grb_word), 32'hFF0055);
    check("t1_led_count_hold", 32'(led_count), 32'd1);

    // 2: five back-to-back words.
    for (int k = 1; k <= 5; k++) begin
      expect_word(24'(k));
      send_bits(24'(k), 24);
    end
    expect_frame();
    low(LONG_LOW);
    drain("t2");

    // 3: glitch, then a well-formed word that must be ignored until resync.
    expect_err(2'b01);
    pulse(10, 100);
    send_bits(24'hAAAAAA, 24);
    low(LONG_LOW);
    drain("t3a");
    check("t3_err_code_hold", 32'(err_code), 32'd1);
    expect_word(24'h0F0F0F);
    send_bits(24'h0F0F0F, 24);
    expect_frame();
    low(LONG_LOW);
    drain("t3b");

    // 4: stuck high; the error must appear while din is still high.
    expect_err(2'b10);
    din = 1'b1;
    repeat (200) @(negedge clk);
    check("t4_err_while_high", 32'(err_q.size()), 32'd0);
    low(LONG_LOW);
    drain("t4");

    // 5: partial word at RESET.
    expect_err(2'b11);
    send_bits(24'hABC000, 12);
    low(LONG_LOW);
    drain("t5");
    check("t5_led_count_hold", 32'(led_count), 32'(model_led));
    check("t5_err_code_hold", 32'(err_code), 32'd3);
    low(LONG_LOW);

    // 6: reset in the middle of a word, then full sync and one word.
    send_bits(24'hFFFFFF, 13);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_idx = 8'd0;
    model_led = 8'd0;
    check_reset_values("t6_rst");
    low(LONG_LOW);
    expect_word(24'h123456);
    send_bits(24'h123456, 24);
    expect_frame();
    low(LONG_LOW);
    drain("t6");
    check("t6_grb_word", 32'(grb_word), 32'h123456);
    check("t6_led_count", 32'(led_count), 32'd1);

    // 7: threshold sweep. 14 glitches; 15/59 give '0', 60/120 give '1'.
    expect_err(2'b01);
    pulse(14, 100);
    low(LONG_LOW);
    drain("t7_glitch");
    expect_word(24'h300000);
    pulse(15, 88);
    pulse(59, 88);
    pulse(60, 88);
    pulse(120, 88);
    for (int i = 0; i < 20; i++) send_bit(1'b0);
    expect_frame();
    low(LONG_LOW);
    drain("t7_word");
    expect_err(2'b10);
    pulse(121, LONG_LOW);
    drain("t7_stuck");
    check("t7_err_code", 32'(err_code), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
